mem_rr_arbiter: RTL and testbench

- 2-to-1 arbiter for the MEM bus protocol (req/gnt/valid/addr/wdata/we/be/rdata).
- Lets the core wrapper's instruction and data MEM masters share one MEM slave port, e.g. a single BRAM or a single MEM-to-AXI bridge.
- Arbitration is round-robin with request locking.
- A small ID FIFO records which master owns each outstanding transaction, so in-order responses return to the correct master.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_id_fifo.sv | 60 ++++++
 rtl/mem_rr_arbiter_chk.sv | 27 ++
 rtl/mem_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MEM bus round-robin arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef logic [0:0] mem_master_id_t;

  typedef enum logic [0:0] {
    MASTER_INSTR = 1'b0,
    MASTER_DATA  = 1'b1
  } mem_master_e;

  // Returns the master that is not the given one.
  function automatic mem_master_id_t other_master(input mem_master_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Owner-ID FIFO: records which master issued each outstanding MEM transaction
// so that in-order responses can be steered back to it.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push,
  input  mem_master_id_t push_id,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output mem_master_id_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  mem_master_id_t   mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  // Overflowing pushes and underflowing pops are dropped rather than corrupting state.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= MASTER_INSTR;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_id;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_rr_arbiter_chk.sv
// Simulation checker: flags a slave response that arrives with nothing outstanding.
module mem_rr_arbiter_chk (
  input logic clk_i,
  input logic rst_i,
  input logic s_mem_valid,
  input logic fifo_empty
);

  logic err_seen_r;

  // Sticky record of an orphan response since the last reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_seen_r <= 1'b0;
    end else if (s_mem_valid && fifo_empty) begin
      err_seen_r <= 1'b1;
    end else begin
      err_seen_r <= err_seen_r;
    end
  end

  orphan_response_a: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(s_mem_valid && fifo_empty && !err_seen_r)
  ) else $warning("mem_rr_arbiter: slave response with no outstanding transaction, dropped");

endmodule

// File: rtl/mem_rr_arbiter.sv
// 2-to-1 round-robin MEM bus arbiter with request locking and in-order
// response routing through a small owner-ID FIFO.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_mem_req,
  output logic                    m0_mem_gnt,
  output logic                    m0_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   m0_mem_addr,
  input  logic [DATA_WIDTH-1:0]   m0_mem_wdata,
  input  logic                    m0_mem_we,
  input  logic [DATA_WIDTH/8-1:0] m0_mem_be,
  output logic [DATA_WIDTH-1:0]   m0_mem_rdata,
  input  logic                    m1_mem_req,
  output logic                    m1_mem_gnt,
  output logic                    m1_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   m1_mem_addr,
  input  logic [DATA_WIDTH-1:0]   m1_mem_wdata,
  input  logic                    m1_mem_we,
  input  logic [DATA_WIDTH/8-1:0] m1_mem_be,
  output logic [DATA_WIDTH-1:0]   m1_mem_rdata,
  output logic                    s_mem_req,
  input  logic                    s_mem_gnt,
  input  logic                    s_mem_valid,
  output logic [ADDR_WIDTH-1:0]   s_mem_addr,
  output logic [DATA_WIDTH-1:0]   s_mem_wdata,
  output logic                    s_mem_we,
  output logic [DATA_WIDTH/8-1:0] s_mem_be,
  input  logic [DATA_WIDTH-1:0]   s_mem_rdata
);

  logic [NUM_MASTERS-1:0] req_vec_s;
  mem_master_id_t         sel_s;
  mem_master_id_t         rr_last_r;
  mem_master_id_t         lock_id_r;
  logic                   lock_valid_r;
  logic                   accept_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  mem_master_id_t         fifo_head_s;
  logic                   resp_s;

  assign req_vec_s = {m1_mem_req, m0_mem_req};

  // Pick the master to present: a locked (stalled) request keeps the bus,
  // otherwise a lone requester, otherwise whoever was not served last.
  always_comb begin
    sel_s = MASTER_INSTR;
    if (lock_valid_r) begin
      sel_s = lock_id_r;
    end else begin
      case (req_vec_s)
        2'b01:   sel_s = MASTER_INSTR;
        2'b10:   sel_s = MASTER_DATA;
        2'b11:   sel_s = other_master(rr_last_r);
        default: sel_s = MASTER_INSTR;
      endcase
    end
  end

  // Forward the selected master's command to the slave.
  always_comb begin
    s_mem_addr  = m0_mem_addr;
    s_mem_wdata = m0_mem_wdata;
    s_mem_we    = m0_mem_we;
    s_mem_be    = m0_mem_be;
    if (sel_s == MASTER_DATA) begin
      s_mem_addr  = m1_mem_addr;
      s_mem_wdata = m1_mem_wdata;
      s_mem_we    = m1_mem_we;
      s_mem_be    = m1_mem_be;
    end else begin
      s_mem_addr  = m0_mem_addr;
      s_mem_wdata = m0_mem_wdata;
      s_mem_we    = m0_mem_we;
      s_mem_be    = m0_mem_be;
    end
  end

  // Requests are held off while the ID FIFO has no room, and everything is
  // quiet during reset.
  assign s_mem_req  = (|req_vec_s) & ~fifo_full_s & ~rst_i;
  assign accept_s   = s_mem_req & s_mem_gnt;
  assign m0_mem_gnt = accept_s & (sel_s == MASTER_INSTR);
  assign m1_mem_gnt = accept_s & (sel_s == MASTER_DATA);

  // Responses: only valid is steered; rdata fans out to both masters.
  assign resp_s       = s_mem_valid & ~fifo_empty_s & ~rst_i;
  assign m0_mem_valid = resp_s & (fifo_head_s == MASTER_INSTR);
  assign m1_mem_valid = resp_s & (fifo_head_s == MASTER_DATA);
  assign m0_mem_rdata = s_mem_rdata;
  assign m1_mem_rdata = s_mem_rdata;

  // Round-robin history and request lock; a full FIFO leaves the lock untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_r    <= MASTER_DATA;
      lock_valid_r <= 1'b0;
      lock_id_r    <= MASTER_INSTR;
    end else if (accept_s) begin
      rr_last_r    <= sel_s;
      lock_valid_r <= 1'b0;
      lock_id_r    <= lock_id_r;
    end else if (s_mem_req) begin
      rr_last_r    <= rr_last_r;
      lock_valid_r <= 1'b1;
      lock_id_r    <= sel_s;
    end else begin
      rr_last_r    <= rr_last_r;
      lock_valid_r <= lock_valid_r;
      lock_id_r    <= lock_id_r;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (accept_s),
    .push_id (sel_s),
    .pop     (resp_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (fifo_head_s)
  );

  mem_rr_arbiter_chk u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_mem_valid (s_mem_valid),
    .fifo_empty  (fifo_empty_s)
  );

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter.
module tb_mem_rr_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_mem_req, m0_mem_gnt, m0_mem_valid, m0_mem_we;
  logic [AW-1:0] m0_mem_addr;
  logic [DW-1:0] m0_mem_wdata, m0_mem_rdata;
  logic [BW-1:0] m0_mem_be;
  logic          m1_mem_req, m1_mem_gnt, m1_mem_valid, m1_mem_we;
  logic [AW-1:0] m1_mem_addr;
  logic [DW-1:0] m1_mem_wdata, m1_mem_rdata;
  logic [BW-1:0] m1_mem_be;
  logic          s_mem_req, s_mem_gnt, s_mem_valid, s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata, s_mem_rdata;
  logic [BW-1:0] s_mem_be;

  int n_checks = 0;
  int n_errors = 0;

  mem_rr_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .m0_mem_req (m0_mem_req), .m0_mem_gnt (m0_mem_gnt), .m0_mem_valid (m0_mem_valid),
    .m0_mem_addr (m0_mem_addr), .m0_mem_wdata (m0_mem_wdata), .m0_mem_we (m0_mem_we),
    .m0_mem_be (m0_mem_be), .m0_mem_rdata (m0_mem_rdata),
    .m1_mem_req (m1_mem_req), .m1_mem_gnt (m1_mem_gnt), .m1_mem_valid (m1_mem_valid),
    .m1_mem_addr (m1_mem_addr), .m1_mem_wdata (m1_mem_wdata), .m1_mem_we (m1_mem_we),
    .m1_mem_be (m1_mem_be), .m1_mem_rdata (m1_mem_rdata),
    .s_mem_req (s_mem_req), .s_mem_gnt (s_mem_gnt), .s_mem_valid (s_mem_valid),
    .s_mem_addr (s_mem_addr), .s_mem_wdata (s_mem_wdata), .s_mem_we (s_mem_we),
    .s_mem_be (s_mem_be), .s_mem_rdata (s_mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    m0_mem_req = 1'b0; m0_mem_addr = '0; m0_mem_wdata = '0; m0_mem_we = 1'b0; m0_mem_be = 4'hF;
    m1_mem_req = 1'b0; m1_mem_addr = '0; m1_mem_wdata = '0; m1_mem_we = 1'b0; m1_mem_be = 4'hF;
    s_mem_gnt = 1'b0; s_mem_valid = 1'b0; s_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    tick();
    // Reset: outputs held low even with live requests/grants/responses.
    m0_mem_req = 1'b1; m1_mem_req = 1'b1; s_mem_gnt = 1'b1; s_mem_valid = 1'b1;
    settle();
    check("rst_s_req", s_mem_req, 0);
    check("rst_m0_gnt", m0_mem_gnt, 0);
    check("rst_m1_gnt", m1_mem_gnt, 0);
    check("rst_m0_valid", m0_mem_valid, 0);
    check("rst_m1_valid", m1_mem_valid, 0);
    tick();
    idle();
    rst_i = 1'b0;
    tick();

    // Single master read.
    m0_mem_req = 1'b1; m0_mem_addr = 32'h100; s_mem_gnt = 1'b1;
    settle();
    check("t1_m0_gnt", m0_mem_gnt, 1);
    check("t1_m1_gnt", m1_mem_gnt, 0);
    check("t1_s_addr", s_mem_addr, 32'h100);
    tick();
    idle();
    settle();
    check("t1_c1_m0_valid", m0_mem_valid, 0);
    tick();
    s_mem_valid = 1'b1; s_mem_rdata = 32'hDEADBEEF;
    settle();
    check("t1_m0_valid", m0_mem_valid, 1);
    check("t1_m0_rdata", m0_mem_rdata, 32'hDEADBEEF);
    check("t1_m1_valid", m1_mem_valid, 0);
    tick();
    idle();

    // Contention from reset: grants alternate m0,m1,...; responses follow.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      m0_mem_req = (k < 6); m0_mem_addr = 32'h200;
      m1_mem_req = (k < 6); m1_mem_addr = 32'h300;
      s_mem_gnt = 1'b1;
      s_mem_valid = (k >= 1);
      s_mem_rdata = 32'hA000 + k;
      settle();
      if (k < 6) begin
        check("t2_m0_gnt", m0_mem_gnt, (k % 2) == 0);
        check("t2_m1_gnt", m1_mem_gnt, (k % 2) == 1);
        check("t2_s_addr", s_mem_addr, ((k % 2) == 0) ? 32'h200 : 32'h300);
      end
      check("t2_m0_valid", m0_mem_valid, (k >= 1) && (((k - 1) % 2) == 0));
      check("t2_m1_valid", m1_mem_valid, (k >= 1) && (((k - 1) % 2) == 1));
      check("t2_m1_rdata", m1_mem_rdata, 32'hA000 + k);
      tick();
    end
    idle();

    // One m0 transaction so the round-robin history points at m0.
    m0_mem_req = 1'b1; s_mem_gnt = 1'b1;
    settle();
    check("t3_pre_gnt", m0_mem_gnt, 1);
    tick();
    idle();
    s_mem_valid = 1'b1;
    settle();
    check("t3_pre_valid", m0_mem_valid, 1);
    tick();
    idle();

    // Lock: stalled m0 keeps the bus although m1 would win round-robin.
    for (int k = 0; k < 5; k++) begin
      m0_mem_req = (k < 4); m0_mem_addr = 32'h400;
      m1_mem_req = (k >= 1); m1_mem_addr = 32'h500;
      s_mem_gnt = (k >= 3);
      settle();
      check("t3_s_addr", s_mem_addr, (k < 4) ? 32'h400 : 32'h500);
      check("t3_m0_gnt", m0_mem_gnt, k == 3);
      check("t3_m1_gnt", m1_mem_gnt, k == 4);
      tick();
    end
    idle();
    s_mem_valid = 1'b1;
    settle();
    check("t3_resp0_m0", m0_mem_valid, 1);
    check("t3_resp0_m1", m1_mem_valid, 0);
    tick();
    settle();
    check("t3_resp1_m0", m0_mem_valid, 0);
    check("t3_resp1_m1", m1_mem_valid, 1);
    tick();
    idle();

    // Full: four accepted, fifth stalls until one response frees a slot.
    for (int k = 0; k < 7; k++) begin
      m0_mem_req = 1'b1; m0_mem_addr = 32'h800 + 4 * k;
      s_mem_gnt = 1'b1;
      s_mem_valid = (k == 5);
      settle();
      check("t4_s_req", s_mem_req, (k < 4) || (k == 6));
      check("t4_m0_gnt", m0_mem_gnt, (k < 4) || (k == 6));
      check("t4_m0_valid", m0_mem_valid, k == 5);
      if (k == 6) begin
        break;
      end
      tick();
    end
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      s_mem_valid = 1'b1;
      settle();
      check("t4_drain", m0_mem_valid, 1);
      tick();
    end
    idle();

    // Interleaved routing: m1 write, m0 read, m1 read.
    m1_mem_req = 1'b1; m1_mem_we = 1'b1; m1_mem_wdata = 32'hCAFE; m1_mem_be = 4'h3;
    m1_mem_addr = 32'h640; s_mem_gnt = 1'b1;
    settle();
    check("t5_m1_gnt_w", m1_mem_gnt, 1);
    check("t5_s_we", s_mem_we, 1);
    check("t5_s_wdata", s_mem_wdata, 32'hCAFE);
    check("t5_s_be", s_mem_be, 4'h3);
    tick();
    idle();
    m0_mem_req = 1'b1; m0_mem_addr = 32'h600; s_mem_gnt = 1'b1;
    settle();
    check("t5_m0_gnt", m0_mem_gnt, 1);
    check("t5_s_we_rd", s_mem_we, 0);
    tick();
    idle();
    m1_mem_req = 1'b1; m1_mem_addr = 32'h700; s_mem_gnt = 1'b1;
    settle();
    check("t5_m1_gnt_r", m1_mem_gnt, 1);
    check("t5_s_addr", s_mem_addr, 32'h700);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      s_mem_valid = 1'b1;
      settle();
      check("t5_m0_valid", m0_mem_valid, k == 1);
      check("t5_m1_valid", m1_mem_valid, k != 1);
      tick();
    end
    idle();

    // Reset with two outstanding, then a stray response and a fresh request.
    m0_mem_req = 1'b1; s_mem_gnt = 1'b1;
    tick();
    tick();
    rst_i = 1'b1; s_mem_valid = 1'b1;
    settle();
    check("t6_rst_s_req", s_mem_req, 0);
    check("t6_rst_m0_gnt", m0_mem_gnt, 0);
    check("t6_rst_m0_valid", m0_mem_valid, 0);
    check("t6_rst_m1_valid", m1_mem_valid, 0);
    tick();
    rst_i = 1'b0;
    idle();
    s_mem_valid = 1'b1;
    settle();
    check("t6_stray_m0", m0_mem_valid, 0);
    check("t6_stray_m1", m1_mem_valid, 0);
    tick();
    idle();
    m0_mem_req = 1'b1; m1_mem_req = 1'b1; s_mem_gnt = 1'b1;
    settle();
    check("t6_post_m0_gnt", m0_mem_gnt, 1);
    check("t6_post_m1_gnt", m1_mem_gnt, 0);
    tick();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
